multiport_register_file: RTL and testbench



---
 rtl/multiport_register_file_if.sv | 38 +++
 rtl/multiport_register_file.sv | 122 ++++++++++++
 tb/tb_multiport_register_file.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/multiport_register_file_if.sv
// -----------------------------------------------------------------------------
// multiport_register_file_if
// Bus bundle between the register file and its user (decode/execute side).
//   read_addr    : N_READ packed read addresses, port k at [k*N_REG_ADDR +: N_REG_ADDR]
//   read_data    : N_READ packed read data, port k at [k*N_DATA +: N_DATA]
//   write_enable : write strobe
//   write_addr   : write address
//   write_data   : write data
//   clear_start  : request a full-array clear
//   busy         : clear engine active
//   clear_done   : one-cycle pulse on the final clear cycle
// The master drives addresses, write and clear requests; the slave (the
// register file) drives read data and status.
// -----------------------------------------------------------------------------
interface multiport_register_file_if #(
  parameter int N_REG_ADDR = 5,
  parameter int N_DATA     = 32,
  parameter int N_READ     = 2
);
  logic [N_READ*N_REG_ADDR-1:0] read_addr;
  logic [N_READ*N_DATA-1:0]     read_data;
  logic                         write_enable;
  logic [N_REG_ADDR-1:0]        write_addr;
  logic [N_DATA-1:0]            write_data;
  logic                         clear_start;
  logic                         busy;
  logic                         clear_done;

  modport master (
    output read_addr, write_enable, write_addr, write_data, clear_start,
    input  read_data, busy, clear_done
  );

  modport slave (
    input  read_addr, write_enable, write_addr, write_data, clear_start,
    output read_data, busy, clear_done
  );
endinterface

// File: rtl/multiport_register_file.sv
// -----------------------------------------------------------------------------
// multiport_register_file
// Integer register file with N_READ combinational read ports, one write port,
// hardwired-zero entry 0, optional same-cycle write-to-read bypass and a
// sequential clear engine that zeroes entries 1..N_REG-1, one per cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (clears array and engine)
//   bus : multiport_register_file_if.slave (read/write/clear bundle)
// -----------------------------------------------------------------------------
module multiport_register_file #(
  parameter int N_REG_ADDR = 5,
  parameter int N_REG      = 32,
  parameter int N_DATA     = 32,
  parameter int N_READ     = 2,
  parameter int BYPASS     = 1
) (
  input logic                       clk,
  input logic                       rst,
  multiport_register_file_if.slave  bus
);

  localparam logic [N_REG_ADDR-1:0] LAST_IDX  = N_REG_ADDR'(N_REG - 1);
  localparam logic [N_REG_ADDR-1:0] ZERO_ADDR = {N_REG_ADDR{1'b0}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [N_REG_ADDR-1:0] r_count;
  logic [N_REG_ADDR-1:0] w_count_nxt;

  // Entry 0 is hardwired to zero, so storage starts at index 1.
  logic [N_DATA-1:0]     r_mem [1:N_REG-1];

  // State and clear-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= ZERO_ADDR;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic: clear walks entries 1..N_REG-1, then returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (bus.clear_start) begin
          w_state_nxt = S_CLEAR;
          w_count_nxt = N_REG_ADDR'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_count_nxt = r_count;
        end
      end
      S_CLEAR: begin
        // clear_start is deliberately not looked at here: no restart, no queueing.
        if (r_count == LAST_IDX) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = ZERO_ADDR;
        end else begin
          w_state_nxt = S_CLEAR;
          w_count_nxt = r_count + N_REG_ADDR'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = ZERO_ADDR;
      end
    endcase
  end

  // Storage update: clear engine has priority and locks out normal writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < N_REG; i++) begin
        r_mem[i] <= {N_DATA{1'b0}};
      end
    end else if (r_state == S_CLEAR) begin
      r_mem[r_count] <= {N_DATA{1'b0}};
    end else if (bus.write_enable && (bus.write_addr != ZERO_ADDR)) begin
      r_mem[bus.write_addr] <= bus.write_data;
    end
  end

  // Status flags are pure decodes of registered state, so they cannot glitch on inputs.
  assign bus.busy       = (r_state == S_CLEAR);
  assign bus.clear_done = (r_state == S_CLEAR) && (r_count == LAST_IDX);

  genvar k;
  generate
    for (k = 0; k < N_READ; k++) begin : g_rd
      logic [N_REG_ADDR-1:0] w_ra;
      logic [N_DATA-1:0]     w_rd;

      assign w_ra = bus.read_addr[k*N_REG_ADDR +: N_REG_ADDR];

      // Read mux: zero while clearing or for x0, else bypass or stored entry.
      always_comb begin
        w_rd = {N_DATA{1'b0}};
        if ((r_state != S_IDLE) || (w_ra == ZERO_ADDR)) begin
          w_rd = {N_DATA{1'b0}};
        end else if ((BYPASS != 0) && bus.write_enable && (bus.write_addr == w_ra)) begin
          w_rd = bus.write_data;
        end else begin
          w_rd = r_mem[w_ra];
        end
      end

      assign bus.read_data[k*N_DATA +: N_DATA] = w_rd;
    end
  endgenerate

endmodule

// File: tb/tb_multiport_register_file.sv
// -----------------------------------------------------------------------------
// tb_multiport_register_file
// Drives a BYPASS=1 and a BYPASS=0 register file with identical stimulus.
// A reference model (plain array plus a "clear cycles remaining" count) pushes
// the expected per-cycle outputs into a queue; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_multiport_register_file;
  localparam int A = 5;
  localparam int D = 32;
  localparam int R = 2;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  multiport_register_file_if #(.N_REG_ADDR(A), .N_DATA(D), .N_READ(R)) bus_a ();
  multiport_register_file_if #(.N_REG_ADDR(A), .N_DATA(D), .N_READ(R)) bus_b ();

  multiport_register_file #(.N_REG_ADDR(A), .N_REG(NR), .N_DATA(D), .N_READ(R), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  multiport_register_file #(.N_REG_ADDR(A), .N_REG(NR), .N_DATA(D), .N_READ(R), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic [R*D-1:0] rd_a;
    logic [R*D-1:0] rd_b;
    logic           busy;
    logic           done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state.
  logic [D-1:0] mem [NR];
  int           clr_left;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Monitor: every cycle's outputs are compared against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("rd_bypass",   64'(bus_a.read_data), 64'(mon_e.rd_a));
      chk("rd_nobypass", 64'(bus_b.read_data), 64'(mon_e.rd_b));
      chk("busy_a",      64'(bus_a.busy),       64'(mon_e.busy));
      chk("busy_b",      64'(bus_b.busy),       64'(mon_e.busy));
      chk("done_a",      64'(bus_a.clear_done), 64'(mon_e.done));
      chk("done_b",      64'(bus_b.clear_done), 64'(mon_e.done));
    end
  end

  // One clock cycle: apply inputs, queue expectation, advance model at the edge.
  task automatic step(input logic r, input logic we, input logic [A-1:0] wa,
                      input logic [D-1:0] wd, input logic cs,
                      input logic [A-1:0] ra0, input logic [A-1:0] ra1);
    exp_t e;
    logic [A-1:0] ra [R];
    logic [D-1:0] va;
    logic [D-1:0] vb;
    ra[0] = ra0;
    ra[1] = ra1;
    rst = r;
    bus_a.write_enable = we;  bus_b.write_enable = we;
    bus_a.write_addr   = wa;  bus_b.write_addr   = wa;
    bus_a.write_data   = wd;  bus_b.write_data   = wd;
    bus_a.clear_start  = cs;  bus_b.clear_start  = cs;
    bus_a.read_addr    = {ra1, ra0};
    bus_b.read_addr    = {ra1, ra0};
    if (r) begin
      for (int i = 0; i < NR; i++) mem[i] = '0;
      clr_left = 0;
    end
    e.busy = (clr_left > 0);
    e.done = (clr_left == 1);
    for (int p = 0; p < R; p++) begin
      vb = (e.busy || ra[p] == 0) ? 32'h0 : mem[ra[p]];
      va = (!e.busy && ra[p] != 0 && we && wa == ra[p]) ? wd : vb;
      e.rd_a[p*D +: D] = va;
      e.rd_b[p*D +: D] = vb;
    end
    sb.push_back(e);
    @(posedge clk);
    if (!r) begin
      if (clr_left > 0) begin
        mem[NR - clr_left] = '0;
        clr_left--;
      end else begin
        if (we && wa != 0) mem[wa] = wd;
        if (cs) clr_left = NR - 1;
      end
    end
    #1;
  endtask

  task automatic rnd_step(input logic cs);
    step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, NR - 1)), $urandom, cs,
         5'($urandom_range(0, NR - 1)), 5'($urandom_range(0, NR - 1)));
  endtask

  task automatic fill_all();
    for (int i = 1; i < NR; i++)
      step(1'b0, 1'b1, 5'(i), 32'(i) * 32'h1111_1111, 1'b0,
           5'($urandom_range(0, NR - 1)), 5'(i));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mem[i] = '0;
    clr_left = 0;
    #6;
    // Reset state.
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1);
    step(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 1'b0, 5'd31, 5'd9);
    // Release with a write to x5, then read it back, then try writing x0.
    step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd5, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    step(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd5);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5);
    // Same-cycle write/read of x7 (bypass vs. registered visibility).
    step(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd5, 5'd7);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7);
    // Fill, then clear with a simultaneous write to x3; writes and clear pulses during busy.
    fill_all();
    step(1'b0, 1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 5'd3, 5'd4);
    for (int i = 0; i < NR - 1; i++)
      step(1'b0, 1'b1, 5'($urandom_range(1, NR - 1)), $urandom, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, NR - 1)), 5'd3);
    for (int i = 0; i < NR; i++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(NR - 1 - i));
    // clear_start held through a whole clear: exactly one extra clear follows.
    fill_all();
    for (int i = 0; i < NR + 1; i++) rnd_step(1'b1);
    for (int i = 0; i < NR + 4; i++) rnd_step(1'b0);
    // Reset during a clear.
    fill_all();
    step(1'b0, 1'b1, 5'd20, 32'h5555_AAAA, 1'b0, 5'd20, 5'd19);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd19);
    for (int i = 0; i < 9; i++) rnd_step(1'b0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd30);
    step(1'b0, 1'b1, 5'd20, 32'h0000_0001, 1'b0, 5'd20, 5'd30);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd30);
    // Random traffic with occasional clears.
    for (int i = 0; i < 300; i++) rnd_step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
